// File: rtl/seg7_pkg.sv
// Shared constants and scan-state type for the 7-segment readback decoder.
package seg7_pkg;

  localparam logic [6:0] SEG7_D0 = 7'b1111110;
  localparam logic [6:0] SEG7_D1 = 7'b0110000;
  localparam logic [6:0] SEG7_D2 = 7'b1101101;
  localparam logic [6:0] SEG7_D3 = 7'b1111001;
  localparam logic [6:0] SEG7_D4 = 7'b0110011;
  localparam logic [6:0] SEG7_D5 = 7'b1011011;
  localparam logic [6:0] SEG7_D6 = 7'b1011111;
  localparam logic [6:0] SEG7_D7 = 7'b1110000;
  localparam logic [6:0] SEG7_D8 = 7'b1111111;
  localparam logic [6:0] SEG7_D9 = 7'b1111011;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CONFIRM,
    LOCKED
  } scan_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment (a..g, active-high) to BCD decode with a legality flag.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       legal
);

  always_comb begin
    bcd   = BCD_INVALID;
    legal = 1'b1;
    case (seg)
      SEG7_D0: bcd = 4'd0;
      SEG7_D1: bcd = 4'd1;
      SEG7_D2: bcd = 4'd2;
      SEG7_D3: bcd = 4'd3;
      SEG7_D4: bcd = 4'd4;
      SEG7_D5: bcd = 4'd5;
      SEG7_D6: bcd = 4'd6;
      SEG7_D7: bcd = 4'd7;
      SEG7_D8: bcd = 4'd8;
      SEG7_D9: bcd = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 7-segment bus, rebuilds the digit word, publishes it after stable scans.
// Define SEG7_SCAN_ACTIVE_LOW_EN for common-anode displays (seg_in/an_in inverted at the input).
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int  DIGITS       = 6,
  parameter int  STABLE_SCANS = 2,
  localparam int IW           = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_in,
  input  logic [DIGITS-1:0]   an_in,
  output logic [4*DIGITS-1:0] digits_out,
  output logic                frame_valid,
  output logic                err,
  output logic [IW-1:0]       err_digit
);

  localparam logic [3:0] STABLE = 4'(STABLE_SCANS);
  localparam int         W      = 4 * DIGITS;

  logic [6:0]        seg_d, seg_r;
  logic [DIGITS-1:0] an_d, an_r, an_h;
  logic [W-1:0]      work_buf, work_n, last_scan, last_n;
  logic [DIGITS-1:0] seen, seen_n;
  logic [3:0]        cnt, cnt_n;
  logic [3:0]        bcd;
  logic              legal, sample, illegal, complete, equal, publish;
  logic [IW-1:0]     idx;
  scan_state_t       state, state_n;

`ifdef SEG7_SCAN_ACTIVE_LOW_EN
  assign seg_d = ~seg_in;
  assign an_d  = ~an_in;
`else
  assign seg_d = seg_in;
  assign an_d  = an_in;
`endif

  seg7_to_bcd u_dec (
    .seg   (seg_r),
    .bcd   (bcd),
    .legal (legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r     <= '0;
      an_r      <= '0;
      an_h      <= '0;
      work_buf  <= '0;
      last_scan <= '0;
      seen      <= '0;
      cnt       <= '0;
    end else begin
      seg_r     <= seg_d;
      an_r      <= an_d;
      an_h      <= an_r;
      work_buf  <= work_n;
      last_scan <= last_n;
      seen      <= seen_n;
      cnt       <= cnt_n;
    end
  end

  // Only the second and later cycles of a one-hot dwell are trusted.
  always_comb begin
    sample   = $onehot(an_r) && (an_r == an_h);
    idx      = '0;
    work_n   = work_buf;
    last_n   = last_scan;
    seen_n   = seen;
    cnt_n    = cnt;
    illegal  = 1'b0;
    complete = 1'b0;
    equal    = 1'b0;
    publish  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (an_r[i]) idx = IW'(i);
    end
    if (sample) begin
      if (!legal) begin
        illegal = 1'b1;
        work_n  = '0;
        seen_n  = '0;
        cnt_n   = '0;
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          if (an_r[i]) begin
            work_n[4*i +: 4] = bcd;
            seen_n[i]        = 1'b1;
          end
        end
        if (&seen_n) begin
          complete = 1'b1;
          equal    = (work_n == last_scan);
          if (!equal)
            cnt_n = 4'd1;
          else if (cnt < STABLE)
            cnt_n = cnt + 4'd1;
          last_n  = work_n;
          seen_n  = '0;
          // A saturated identical run has already been published.
          publish = (cnt_n == STABLE) && !(equal && (cnt == STABLE));
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    if (illegal)
      state_n = IDLE;
    else if (complete)
      state_n = (cnt_n == STABLE) ? LOCKED : CONFIRM;
    else if (sample && (state == IDLE))
      state_n = COLLECT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_out  <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      err_digit   <= '0;
    end else begin
      frame_valid <= publish;
      err         <= illegal;
      if (publish) digits_out <= work_n;
      if (illegal) err_digit  <= idx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomized scoreboard bench for seg7_scan_decoder against a digit-level reference model.
module tb_seg7_scan_decoder;

  localparam int STABLE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [5:0]  an_in;
  logic [23:0] digits_out;
  logic        frame_valid, err;
  logic [2:0]  err_digit;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.DIGITS(6), .STABLE_SCANS(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digits_out  (digits_out),
    .frame_valid (frame_valid),
    .err         (err),
    .err_digit   (err_digit)
  );

  int n_tests = 0, n_fail = 0, fv_cnt = 0, err_cnt = 0;
  logic [23:0] fv_q[$];
  int          err_q[$];

  logic [6:0] pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                           7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  // Reference model: digit values as ints, run length of identical complete scans.
  logic [5:0] m_prev, m_seen;
  int         m_buf[6], m_last[6], m_run;

  function void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  function void model_reset();
    m_prev = '0;
    m_seen = '0;
    m_run  = 0;
    for (int k = 0; k < 6; k++) begin
      m_buf[k]  = 0;
      m_last[k] = 0;
    end
  endfunction

  function void model_step(logic [6:0] s, logic [5:0] a);
    int d, v;
    bit same;
    logic [23:0] w;
    if ($countones(a) == 1 && a == m_prev) begin
      d = 0;
      for (int k = 0; k < 6; k++) if (a[k]) d = k;
      v = -1;
      for (int k = 0; k < 10; k++) if (pat[k] == s) v = k;
      if (v < 0) begin
        err_q.push_back(d);
        m_seen = '0;
        m_run  = 0;
      end else begin
        m_buf[d]  = v;
        m_seen[d] = 1'b1;
        if (m_seen == 6'h3F) begin
          same = 1;
          for (int k = 0; k < 6; k++) if (m_buf[k] != m_last[k]) same = 0;
          m_run = same ? m_run + 1 : 1;
          if (m_run == STABLE) begin
            w = '0;
            for (int k = 0; k < 6; k++) w[4*k +: 4] = 4'(m_buf[k]);
            fv_q.push_back(w);
          end
          m_last = m_buf;
          m_seen = '0;
        end
      end
    end
    m_prev = a;
  endfunction

  task automatic cyc(input logic [6:0] s, input logic [5:0] a);
    @(negedge clk);
`ifdef SEG7_SCAN_ACTIVE_LOW_EN
    seg_in = ~s;
    an_in  = ~a;
`else
    seg_in = s;
    an_in  = a;
`endif
    model_step(s, a);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(7'h00, 6'h00);
  endtask

  // One scan over digits 0..5; bad_rate>0 randomly corrupts a digit pattern.
  task automatic scan(input logic [23:0] w, input int dmin, input int dmax, input int bad_rate);
    logic [6:0] s;
    int dw;
    for (int i = 0; i < 6; i++) begin
      s = pat[w[4*i +: 4]];
      if (bad_rate > 0 && $urandom_range(0, bad_rate) == 0) s = 7'($urandom);
      dw = $urandom_range(dmin, dmax);
      repeat (dw) cyc(s, 6'(1 << i));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_valid) begin
        fv_cnt++;
        if (fv_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame_valid: digits_out=%h, required no pulse", digits_out);
        end else begin
          chk("frame_digits", 32'(digits_out), 32'(fv_q.pop_front()));
        end
      end
      if (err) begin
        err_cnt++;
        if (err_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_err: err_digit=%0d, required no pulse", err_digit);
        end else begin
          chk("err_digit", 32'(err_digit), 32'(err_q.pop_front()));
        end
      end
    end
  end

  logic [23:0] rv;
  int fv0, er0;

  initial begin
    model_reset();
    rst_n = 1'b0;
`ifdef SEG7_SCAN_ACTIVE_LOW_EN
    seg_in = 7'h7F;
    an_in  = 6'h3F;
`else
    seg_in = 7'h00;
    an_in  = 6'h00;
`endif
    repeat (3) @(negedge clk);
    chk("reset_digits", 32'(digits_out), 32'h0);
    chk("reset_fv", 32'(frame_valid), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_err_digit", 32'(err_digit), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Steady 12:34:56, three scans: exactly one publish.
    repeat (3) scan(24'h123456, 4, 4, 0);
    idle(4);
    chk("steady_fv_count", 32'(fv_cnt), 32'd1);
    chk("steady_digits", 32'(digits_out), 32'h123456);
    chk("steady_err_count", 32'(err_cnt), 32'd0);

    // Seconds-units change.
    repeat (2) scan(24'h123457, 4, 4, 0);
    idle(4);
    chk("change_fv_count", 32'(fv_cnt), 32'd2);
    chk("change_digits", 32'(digits_out), 32'h123457);

    // Illegal pattern on digit 3 mid-scan.
    for (int i = 0; i < 3; i++) repeat (3) cyc(pat[(i == 0) ? 7 : (i == 1) ? 5 : 4], 6'(1 << i));
    repeat (2) cyc(7'b0000001, 6'b001000);
    idle(4);
    chk("illegal_err_count", 32'(err_cnt), 32'd1);
    chk("illegal_err_digit", 32'(err_digit), 32'd3);
    scan(24'h123457, 3, 3, 0);
    idle(4);
    chk("illegal_one_scan_no_fv", 32'(fv_cnt), 32'd2);
    scan(24'h123457, 3, 3, 0);
    idle(4);
    chk("illegal_relock_fv", 32'(fv_cnt), 32'd3);
    chk("illegal_err_digit_held", 32'(err_digit), 32'd3);

    // Ghost filter: single-cycle dwells and multi-hot enables.
    fv0 = fv_cnt;
    er0 = err_cnt;
    repeat (3) scan(24'h654321, 1, 1, 0);
    repeat (6) cyc(pat[8], 6'b000011);
    repeat (6) cyc(7'b0000001, 6'b000011);
    idle(4);
    chk("ghost_fv", 32'(fv_cnt), 32'(fv0));
    chk("ghost_err", 32'(err_cnt), 32'(er0));
    chk("ghost_digits", 32'(digits_out), 32'h123457);

    // Reset mid-scan while locked.
    for (int i = 0; i < 3; i++) repeat (3) cyc(pat[9], 6'(1 << i));
    idle(3);
    chk("pre_reset_queue", 32'(fv_q.size() + err_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_digits", 32'(digits_out), 32'h0);
    chk("midreset_fv", 32'(frame_valid), 32'h0);
    chk("midreset_err", 32'(err), 32'h0);
    chk("midreset_err_digit", 32'(err_digit), 32'h0);
    model_reset();
    idle(2);
    rst_n = 1'b1;
    fv0 = fv_cnt;
    repeat (2) scan(24'h123457, 2, 4, 0);
    idle(4);
    chk("relock_fv", 32'(fv_cnt), 32'(fv0 + 1));
    chk("relock_digits", 32'(digits_out), 32'h123457);

    // Random runs of repeated values with occasional corrupted patterns.
    for (int r = 0; r < 25; r++) begin
      rv = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      repeat ($urandom_range(1, 4)) scan(rv, 2, 5, 40);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(6);
    chk("final_fv_queue_empty", 32'(fv_q.size()), 32'd0);
    chk("final_err_queue_empty", 32'(err_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
